// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core
// Brief    : Multi-cycle accumulator CPU (A/B registers, PC, single memory
//            port, handshaked output port). Optional carry flag enabled by
//            defining CPU_CARRY_FLAG_EN.
// Revision : 1.0
// ============================================================================
module cpu_core #(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);

    localparam logic [2:0] c_ST_FETCH_INST = 3'd0;
    localparam logic [2:0] c_ST_FETCH_ARG  = 3'd1;
    localparam logic [2:0] c_ST_EXEC_MEM   = 3'd2;
    localparam logic [2:0] c_ST_OUT_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_HALT       = 3'd4;

    localparam logic [3:0] c_OP_LDA = 4'd1;
    localparam logic [3:0] c_OP_LDB = 4'd2;
    localparam logic [3:0] c_OP_OUT = 4'd3;
    localparam logic [3:0] c_OP_ADD = 4'd4;
    localparam logic [3:0] c_OP_SUB = 4'd5;
    localparam logic [3:0] c_OP_STA = 4'd6;
    localparam logic [3:0] c_OP_JMP = 4'd7;
    localparam logic [3:0] c_OP_JZ  = 4'd8;
    localparam logic [3:0] c_OP_JNZ = 4'd9;
    localparam logic [3:0] c_OP_JC  = 4'd10;
    localparam logic [3:0] c_OP_HLT = 4'd15;

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_x;
    logic [3:0]        r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    logic [3:0]        w_op_in;
    logic              w_has_arg;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_x_in;
    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_sub;
    logic              w_zero;
    logic              w_carry;
    logic              w_take;

`ifdef CPU_CARRY_FLAG_EN
    logic              r_carry;
    logic [DATA_W:0]   w_sum_ext;

    assign w_sum_ext = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry   = r_carry;
`else
    assign w_carry   = 1'b0;
`endif

    assign w_op_in  = mem_rdata[3:0];
    assign w_x_in   = mem_rdata[ADDR_W-1:0];
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_add    = r_a + r_b;
    assign w_sub    = r_a - r_b;
    assign w_zero   = (r_a == '0);

    always_comb begin
        w_has_arg = 1'b0;
        case (w_op_in)
            c_OP_LDA, c_OP_LDB, c_OP_STA,
            c_OP_JMP, c_OP_JZ, c_OP_JNZ, c_OP_JC: w_has_arg = 1'b1;
            default:                              w_has_arg = 1'b0;
        endcase
    end

    // Branch decision uses the A/carry values present at the resolving edge.
    always_comb begin
        w_take = 1'b0;
        case (r_ir)
            c_OP_JMP: w_take = 1'b1;
            c_OP_JZ:  w_take = w_zero;
            c_OP_JNZ: w_take = !w_zero;
            c_OP_JC:  w_take = w_carry;
            default:  w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_FETCH_INST;
            r_pc    <= c_RESET_PC;
            r_x     <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
`ifdef CPU_CARRY_FLAG_EN
            r_carry <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_FETCH_INST: begin
                    if (mem_ack) begin
                        r_ir <= w_op_in;
                        r_pc <= w_pc_inc;
                        if (w_has_arg) begin
                            r_state <= c_ST_FETCH_ARG;
                        end else begin
                            case (w_op_in)
                                c_OP_ADD: begin
                                    r_a <= w_add;
`ifdef CPU_CARRY_FLAG_EN
                                    r_carry <= w_sum_ext[DATA_W];
`endif
                                    r_state <= c_ST_FETCH_INST;
                                end
                                c_OP_SUB: begin
                                    r_a <= w_sub;
`ifdef CPU_CARRY_FLAG_EN
                                    r_carry <= (r_a >= r_b);
`endif
                                    r_state <= c_ST_FETCH_INST;
                                end
                                c_OP_OUT: r_state <= c_ST_OUT_WAIT;
                                c_OP_HLT: r_state <= c_ST_HALT;
                                default:  r_state <= c_ST_FETCH_INST;
                            endcase
                        end
                    end
                end
                c_ST_FETCH_ARG: begin
                    if (mem_ack) begin
                        r_x <= w_x_in;
                        r_pc <= w_take ? w_x_in : w_pc_inc;
                        if ((r_ir == c_OP_LDA) || (r_ir == c_OP_LDB) || (r_ir == c_OP_STA)) begin
                            r_state <= c_ST_EXEC_MEM;
                        end else begin
                            r_state <= c_ST_FETCH_INST;
                        end
                    end
                end
                c_ST_EXEC_MEM: begin
                    if (mem_ack) begin
                        if (r_ir == c_OP_LDA) begin
                            r_a <= mem_rdata;
                        end
                        if (r_ir == c_OP_LDB) begin
                            r_b <= mem_rdata;
                        end
                        r_state <= c_ST_FETCH_INST;
                    end
                end
                c_ST_OUT_WAIT: begin
                    if (out_ready) begin
                        r_state <= c_ST_FETCH_INST;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_FETCH_INST;
                end
            endcase
        end
    end

    // Request signals are pure functions of registered state, so they stay
    // stable for as long as the memory takes to acknowledge.
    always_comb begin
        mem_addr  = r_pc;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        case (r_state)
            c_ST_FETCH_INST,
            c_ST_FETCH_ARG: begin
                mem_rd = 1'b1;
            end
            c_ST_EXEC_MEM: begin
                mem_addr = r_x;
                mem_rd   = (r_ir != c_OP_STA);
                mem_wr   = (r_ir == c_OP_STA);
            end
            c_ST_OUT_WAIT: begin
                out_valid = 1'b1;
            end
            c_ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                mem_rd = 1'b0;
            end
        endcase
    end

    assign mem_wdata = r_a;
    assign out_data  = r_a;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_core
// Brief    : Scoreboard testbench for cpu_core (8-bit instance with a
//            variable-latency memory model, plus a 16/4-bit wrap instance).
// Revision : 1.0
// ============================================================================
module tb_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;

    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         r_wait = 0;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = (mem_rd || mem_wr) && (r_wait >= ack_delay);

    always @(posedge clk) begin
        if (!reset || !(mem_rd || mem_wr) || mem_ack) r_wait <= 0;
        else                                          r_wait <= r_wait + 1;
    end

    cpu_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
    );

    // ---------------- 16-bit data / 4-bit address instance ----------------
    logic        reset2;
    logic [3:0]  m2_addr;
    logic        m2_rd;
    logic        m2_wr;
    logic [15:0] m2_wdata;
    logic [15:0] m2_rdata;
    logic [15:0] out2_data;
    logic        out2_valid;
    logic        halted2;
    logic [15:0] mem2 [16];

    assign m2_rdata = mem2[m2_addr];

    cpu_core #(.DATA_W(16), .ADDR_W(4), .RESET_PC(8)) u_dut2 (
        .clk       (clk),
        .reset     (reset2),
        .mem_addr  (m2_addr),
        .mem_rd    (m2_rd),
        .mem_wr    (m2_wr),
        .mem_wdata (m2_wdata),
        .mem_rdata (m2_rdata),
        .mem_ack   (1'b1),
        .out_data  (out2_data),
        .out_valid (out2_valid),
        .out_ready (1'b1),
        .halted    (halted2)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] wexp_q [$];
    logic [15:0] exp2_q [$];
    logic [3:0]  f2_q [$];
    logic        p_pend = 1'b0;
    logic [17:0] p_sig = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("out_unexpected", {24'h0, out_data});
                else                   chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
            if (mem_wr && mem_ack) begin
                wr_count++;
                if (wexp_q.size() == 0) fail_now("write_unexpected", {16'h0, mem_addr, mem_wdata});
                else                    chk("write_addr_data", {16'h0, mem_addr, mem_wdata}, {16'h0, wexp_q.pop_front()});
                mem[mem_addr] = mem_wdata;
            end
            if (mem_rd && mem_wr) fail_now("rd_and_wr", {30'h0, mem_rd, mem_wr});
            if (p_pend) chk("req_stable", {14'h0, mem_addr, mem_rd, mem_wr, mem_wdata}, {14'h0, p_sig});
        end
        p_pend = reset && (mem_rd || mem_wr) && !mem_ack;
        p_sig  = {mem_addr, mem_rd, mem_wr, mem_wdata};
    end

    always @(negedge clk) begin
        if (reset2) begin
            if (m2_rd) begin
                if (f2_q.size() == 0) fail_now("fetch2_unexpected", {28'h0, m2_addr});
                else                  chk("fetch2_addr", {28'h0, m2_addr}, {28'h0, f2_q.pop_front()});
            end
            if (m2_wr) fail_now("write2_unexpected", {16'h0, m2_wdata});
            if (out2_valid) begin
                if (exp2_q.size() == 0) fail_now("out2_unexpected", {16'h0, out2_data});
                else                    chk("out2_data", {16'h0, out2_data}, {16'h0, exp2_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load(input int base, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
        mem[base]     = w0;
        mem[base + 1] = w1;
        mem[base + 2] = w2;
        mem[base + 3] = w3;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    task automatic run_until_halt(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !halted; i++) begin
            @(posedge clk); #2;
        end
        chk({name, "_halted"}, {31'h0, halted}, 32'h1);
        chk({name, "_outq_empty"}, exp_q.size(), 32'h0);
        @(posedge clk); #2;
        chk({name, "_halt_idle"}, {30'h0, mem_rd, mem_wr}, 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        reset2    = 1'b0;
        out_ready = 1'b1;
        ack_delay = 0;

        for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;
        mem2[8]  = 16'h0001;   // LDA
        mem2[9]  = 16'h0005;
        mem2[5]  = 16'h1234;
        mem2[10] = 16'h0007;   // JMP 0xF (upper operand bits ignored)
        mem2[11] = 16'hABCF;
        mem2[15] = 16'h00F0;   // NOP (upper opcode bits ignored)
        mem2[0]  = 16'h0003;   // OUT
        mem2[1]  = 16'h000F;   // HLT

        // Basic program: LDA 0x10, LDB 0x11, ADD, OUT, HLT
        clear_mem();
        load(0, 8'h01, 8'h10, 8'h02, 8'h11);
        load(4, 8'h04, 8'h03, 8'h0F, 8'h00);
        mem[8'h10] = 8'h03;
        mem[8'h11] = 8'h04;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        chk("rst_mem_rd",    {31'h0, mem_rd},    32'h1);
        chk("rst_mem_addr",  {24'h0, mem_addr},  32'h0);
        chk("rst_mem_wr",    {31'h0, mem_wr},    32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_halted",    {31'h0, halted},    32'h0);
        exp_q.push_back(8'h07);
        run_until_halt("basic", 100);

        // A=FF + B=01 -> 0, carry out; then JC 0x20
        clear_mem();
        load(0,     8'h01, 8'h40, 8'h02, 8'h41);
        load(4,     8'h04, 8'h03, 8'h0A, 8'h20);
        load(8,     8'h01, 8'h30, 8'h03, 8'h0F);
        load(8'h20, 8'h01, 8'h31, 8'h03, 8'h0F);
        mem[8'h40] = 8'hFF;
        mem[8'h41] = 8'h01;
        mem[8'h30] = 8'h55;
        mem[8'h31] = 8'hAA;
        exp_q.push_back(8'h00);
`ifdef CPU_CARRY_FLAG_EN
        exp_q.push_back(8'hAA);
`else
        exp_q.push_back(8'h55);
`endif
        do_reset();
        run_until_halt("jc", 100);

        // Countdown: A=3, B=1, loop SUB/OUT/JNZ, memory answers after 1 wait
        clear_mem();
        ack_delay = 1;
        load(0, 8'h01, 8'h40, 8'h02, 8'h41);
        load(4, 8'h05, 8'h03, 8'h09, 8'h04);
        load(8, 8'h01, 8'h42, 8'h03, 8'h0F);
        mem[8'h40] = 8'h03;
        mem[8'h41] = 8'h01;
        mem[8'h42] = 8'hEE;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hEE);
        do_reset();
        run_until_halt("countdown", 300);

        // Slow memory (3 wait cycles): LDA, STA, LDB back, ADD, OUT, HLT
        clear_mem();
        ack_delay = 3;
        wr_count  = 0;
        load(0, 8'h01, 8'h40, 8'h06, 8'h50);
        load(4, 8'h02, 8'h50, 8'h04, 8'h03);
        mem[8]     = 8'h0F;
        mem[8'h40] = 8'h5A;
        wexp_q.push_back({8'h50, 8'h5A});
        exp_q.push_back(8'hB4);
        do_reset();
        run_until_halt("slowmem", 400);
        chk("sta_write_count", wr_count, 32'h1);
        chk("sta_mem_value", {24'h0, mem[8'h50]}, 32'h5A);
        chk("wexp_empty", wexp_q.size(), 32'h0);

        // Output back-pressure, then reset while waiting
        clear_mem();
        ack_delay = 0;
        out_ready = 1'b0;
        load(0, 8'h01, 8'h40, 8'h03, 8'h0F);
        mem[8'h40] = 8'h33;
        do_reset();
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #2;
        end
        chk("bp_reached_out", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {22'h0, out_valid, mem_rd, out_data}, {22'h0, 1'b1, 1'b0, 8'h33});
            @(posedge clk); #2;
        end
        do_reset();
        chk("bp_rst_fetch", {14'h0, mem_rd, mem_wr, out_valid, halted, mem_addr},
            {14'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        out_ready = 1'b1;
        exp_q.push_back(8'h33);
        run_until_halt("bp", 100);

        // 16-bit instance: JMP 0xF, NOP at 0xF, PC wraps to 0
        f2_q = '{4'h8, 4'h9, 4'h5, 4'hA, 4'hB, 4'hF, 4'h0, 4'h1};
        exp2_q.push_back(16'h1234);
        @(posedge clk); #2;
        reset2 = 1'b1;
        for (int i = 0; i < 60 && !halted2; i++) begin
            @(posedge clk); #2;
        end
        chk("wrap_halted", {31'h0, halted2}, 32'h1);
        chk("wrap_fetchq_empty", f2_q.size(), 32'h0);
        chk("wrap_outq_empty", exp2_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
